// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response channels,
// the decode-side instruction channel and the branch redirect.
// master: fetch_unit side; slave: memory/decode/branch side.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
               opcode, funct3, funct7,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
               opcode, funct3, funct7,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rv32i instruction fetch stage: owns the PC, issues word reads under a
// credit limit (buffered + outstanding <= FIFO_DEPTH), buffers in-order
// responses and hands one instruction per cycle to decode. A redirect
// flushes the buffer and discards every response still in flight.
// Optional feature macro: FETCH_BYPASS_EN forwards a response straight to
// decode when the buffer is empty (0-cycle response-to-decode latency).
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CMP_W = CNT_W + 1;

    typedef enum logic {StRun, StDrain} state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]      fifo_data_q [FIFO_DEPTH];
    // PC of each accepted request, popped as its response returns
    logic [31:0]      pcq_q       [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, pcq_rd_q, pcq_wr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic credit, req_fire, rsp_keep, head_valid, push, pop;

    // Request issue, decode-side outputs and buffer push/pop decisions
    always_comb begin
        credit = ({1'b0, count_q} + {1'b0, outstanding_q}) < CMP_W'(FIFO_DEPTH);
        bus.imem_req_valid = (state_q == StRun) && !reset && credit;
        bus.imem_req_addr  = fetch_pc_q;
        req_fire   = bus.imem_req_valid && bus.imem_req_ready;
        head_valid = count_q != '0;
        rsp_keep   = bus.imem_rsp_valid && (drop_q == '0);
        pop        = head_valid && bus.instr_ready;
`ifdef FETCH_BYPASS_EN
        // Empty buffer: forward the live response; it skips the buffer if taken now
        if (!head_valid && rsp_keep && (state_q == StRun)) begin
            bus.instr_valid = 1'b1;
            bus.instr       = bus.imem_rsp_data;
            bus.instr_pc    = pcq_q[pcq_rd_q];
            push            = !bus.redirect && !bus.instr_ready;
        end else begin
            bus.instr_valid = head_valid;
            bus.instr       = fifo_data_q[rd_ptr_q];
            bus.instr_pc    = fifo_pc_q[rd_ptr_q];
            push            = rsp_keep && !bus.redirect;
        end
`else
        bus.instr_valid = head_valid;
        bus.instr       = fifo_data_q[rd_ptr_q];
        bus.instr_pc    = fifo_pc_q[rd_ptr_q];
        push            = rsp_keep && !bus.redirect;
`endif
        bus.opcode = bus.instr[6:0];
        bus.funct3 = bus.instr[14:12];
        bus.funct7 = bus.instr[31:25];
    end

    // Next-state for PC, counters and run/drain control
    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
        if (bus.redirect) begin
            // Anything still in flight after this edge (incl. a request accepted now) is stale
            fetch_pc_d = bus.redirect_pc & ~32'h3;
            count_d    = '0;
            drop_d     = outstanding_d;
            state_d    = (outstanding_d != '0) ? StDrain : StRun;
        end else begin
            fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
            count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
            drop_d     = (bus.imem_rsp_valid && (drop_q != '0)) ? drop_q - 1'b1 : drop_q;
            state_d    = (state_q == StDrain && drop_d == '0) ? StRun : state_q;
        end
    end

    // All fetch state, asynchronously cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            pcq_rd_q      <= '0;
            pcq_wr_q      <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
                pcq_q[i]       <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            if (req_fire) begin
                pcq_q[pcq_wr_q] <= fetch_pc_q;
                pcq_wr_q        <= pcq_wr_q + 1'b1;
            end
            if (bus.imem_rsp_valid) begin
                pcq_rd_q <= pcq_rd_q + 1'b1;
            end
            if (bus.redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    fifo_pc_q[wr_ptr_q]   <= pcq_q[pcq_rd_q];
                    fifo_data_q[wr_ptr_q] <= bus.imem_rsp_data;
                    wr_ptr_q              <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a randomised-latency memory, a decode consumer and a
// reference model of the expected instruction stream (sequential PCs,
// restarting at the redirect target or at RESET_PC).
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned DEPTH  = 2;

    logic clk;
    logic reset;
    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // memory behaviour knobs
    bit ready_rand = 1'b0;
    int lat_min    = 1;
    int lat_max    = 1;

    // reference model state
    logic [31:0] exp_pc  = RST_PC;
    int          out_cnt = 0;
    int          n_acc   = 0;
    int          n_hs    = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory: in-order responses, latency lat_min..lat_max cycles after acceptance
    initial begin
        logic [31:0] q_addr [$];
        int          q_due  [$];
        int          cyc;
        cyc = 0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.imem_rsp_valid = 1'b0;
            if (reset) begin
                q_addr.delete();
                q_due.delete();
            end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            bus.imem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (reset) begin
                q_addr.delete();
                q_due.delete();
            end else if (bus.imem_req_valid && bus.imem_req_ready) begin
                q_addr.push_back(bus.imem_req_addr);
                q_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
            end
        end
    end

    // Reference model: every decode handshake must carry the next expected PC
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_pc  = RST_PC;
                out_cnt = 0;
                n_acc   = 0;
                n_hs    = 0;
            end else begin
                if (bus.imem_req_valid) begin
                    check("req_addr_align", {30'd0, bus.imem_req_addr[1:0]}, 32'd0);
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    out_cnt++;
                    n_acc++;
                end
                if (bus.imem_rsp_valid) out_cnt--;
                if (out_cnt > int'(DEPTH) || out_cnt < 0) begin
                    check("outstanding_bound", 32'(out_cnt), 32'(DEPTH));
                end
                if (bus.instr_valid && bus.instr_ready) begin
                    check("instr_pc", bus.instr_pc, exp_pc);
                    check("instr", bus.instr, mem_word(exp_pc));
                    check("fields", {bus.funct7, bus.funct3, bus.opcode, 15'd0},
                          {mem_word(exp_pc)[31:25], mem_word(exp_pc)[14:12],
                           mem_word(exp_pc)[6:0], 15'd0});
                    exp_pc = exp_pc + 32'd4;
                    n_hs++;
                end
                if (bus.redirect) exp_pc = bus.redirect_pc & ~32'h3;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int rsp_seen;
        int target;
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.instr_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_instr_pc", bus.instr_pc, 32'd0);

        // Release: first request at RESET_PC, first instruction in cycle 3
        @(posedge clk);
        #1;
        reset           = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("first_req_addr", bus.imem_req_addr, RST_PC);
        @(negedge clk);
        check("cycle2_instr_valid", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check("cycle3_instr_valid", 32'(bus.instr_valid), 32'd1);
        check("cycle3_instr_pc", bus.instr_pc, RST_PC);
        repeat (30) @(negedge clk);

        // Decode stall: buffer fills to DEPTH, fetch stops, nothing lost
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("stall_buffered", 32'(n_acc - n_hs), 32'(DEPTH));
        check("stall_instr_valid", 32'(bus.instr_valid), 32'd1);
        check("stall_head_pc", bus.instr_pc, exp_pc);
        repeat (3) @(negedge clk);
        check("stall_req_still_0", 32'(bus.imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
        repeat (20) @(negedge clk);

        // Redirect with two requests outstanding
        lat_min = 4;
        lat_max = 4;
        found   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_cnt == 2) begin
                found = 1'b1;
                break;
            end
        end
        check("outstanding_2_reached", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_2003;
        @(negedge clk);
        rsp_seen = bus.imem_rsp_valid ? 1 : 0;
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        lat_min      = 1;
        lat_max      = 1;
        found        = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid) begin
                found = 1'b1;
                break;
            end
            if (bus.imem_rsp_valid) rsp_seen++;
            check("drain_no_instr", 32'(bus.instr_valid), 32'd0);
        end
        check("drain_ends", 32'(found), 32'd1);
        check("drain_dropped", 32'(rsp_seen), 32'd2);
        check("redirect_req_addr", bus.imem_req_addr, 32'h0000_2000);
        repeat (20) @(negedge clk);

        // Redirect coinciding with a decode handshake and a response
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (bus.instr_valid && bus.imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("coincide_found", 32'(found), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_3000;
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        found        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("coincide_valid", 32'(found), 32'd1);
        check("coincide_first_pc", bus.instr_pc, 32'h0000_3000);
        repeat (10) @(negedge clk);

        // Random memory readiness/latency, random decode stalls, rare redirects
        ready_rand = 1'b1;
        lat_min    = 1;
        lat_max    = 4;
        target     = n_hs + 1000;
        found      = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            @(posedge clk);
            #1;
            bus.instr_ready = 1'($urandom_range(0, 1));
            bus.redirect    = ($urandom_range(0, 99) == 0);
            bus.redirect_pc = $urandom;
            if (n_hs >= target) begin
                found = 1'b1;
                break;
            end
        end
        bus.redirect = 1'b0;
        check("random_1000_done", 32'(found), 32'd1);
        ready_rand      = 1'b0;
        lat_min         = 1;
        lat_max         = 1;
        bus.instr_ready = 1'b0;

        // Asynchronous reset with an instruction buffered
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("pre_reset_buffered", 32'(found), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("async_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset           = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check("refetch_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("refetch_req_addr", bus.imem_req_addr, RST_PC);
        repeat (20) @(negedge clk);
        check("refetch_progress", 32'(n_hs > 0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
